// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: md_op encodings, default
// latencies, FSM states and the behavioural arithmetic used at operation start.
package mdu_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_RSVD  = 3'd7
    } md_op_e;

    localparam int unsigned MULT_CYCLES_DEFAULT = 5;
    localparam int unsigned DIV_CYCLES_DEFAULT  = 10;

    typedef enum logic {
        StIdle,
        StRun
    } mdu_state_e;

    typedef struct packed {
        logic        wr;
        logic [31:0] hi;
        logic [31:0] lo;
    } md_result_t;

    function automatic logic md_is_arith(logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic md_is_div(logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    // wr is cleared for a zero divisor so HI/LO keep their old contents.
    function automatic md_result_t md_compute(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        md_result_t  res;
        logic [63:0] prod;
        res  = '0;
        prod = '0;
        case (op)
            MD_MULT: begin
                prod   = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                res.wr = 1'b1;
                res.hi = prod[63:32];
                res.lo = prod[31:0];
            end
            MD_MULTU: begin
                prod   = {32'd0, a} * {32'd0, b};
                res.wr = 1'b1;
                res.hi = prod[63:32];
                res.lo = prod[31:0];
            end
            MD_DIV: begin
                if (b == 32'd0) begin
                    res.wr = 1'b0;
                end else if ((a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
                    // Quotient overflows; wrap to the dividend with zero remainder.
                    res.wr = 1'b1;
                    res.lo = 32'h8000_0000;
                    res.hi = 32'd0;
                end else begin
                    res.wr = 1'b1;
                    res.lo = $signed(a) / $signed(b);
                    res.hi = $signed(a) % $signed(b);
                end
            end
            MD_DIVU: begin
                if (b == 32'd0) begin
                    res.wr = 1'b0;
                end else begin
                    res.wr = 1'b1;
                    res.lo = a / b;
                    res.hi = a % b;
                end
            end
            default: res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mdu.sv
// E-stage multiply/divide unit owning HI/LO. Results are computed at start and
// committed after a fixed latency counted down by cnt.
module mdu
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEFAULT,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        md_en,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        md_use_D,
    output logic        busy,
    output logic        start,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        md_stall
);

    localparam int unsigned MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      res_hi_q, res_hi_d;
    logic [31:0]      res_lo_q, res_lo_d;
    logic             res_wr_q, res_wr_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    md_result_t       result;

    assign busy     = (state_q == StRun);
    assign start    = md_en && md_is_arith(md_op) && !busy;
    assign md_stall = md_use_D && (start || busy);
    assign HI       = hi_q;
    assign LO       = lo_q;
    assign result   = md_compute(md_op, A, B);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        res_wr_d = res_wr_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    res_hi_d = result.hi;
                    res_lo_d = result.lo;
                    res_wr_d = result.wr;
                    cnt_d    = md_is_div(md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                    state_d  = StRun;
                end else if (md_en && (md_op == MD_MTHI)) begin
                    hi_d = A;
                end else if (md_en && (md_op == MD_MTLO)) begin
                    lo_d = A;
                end
            end
            StRun: begin
                // md_en is deliberately ignored here; only the countdown matters.
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = StIdle;
                    if (res_wr_q) begin
                        hi_d = res_hi_q;
                        lo_d = res_lo_q;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            res_wr_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            res_wr_q <= res_wr_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

endmodule
